// File: rtl/image2dram_pkg.sv
// Shared types and constants for the DRAM frame read-back path.
package image2dram_pkg;

  localparam int DRAM_BEAT_BITS  = 512;
  localparam int BYTES_PER_BEAT  = DRAM_BEAT_BITS / 8;
  localparam int BEAT_ADDR_SHIFT = $clog2(BYTES_PER_BEAT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN
  } rd_state_t;

endpackage

// File: rtl/frame_reader_fifo.sv
// First-word fall-through beat FIFO with occupancy count; head data is visible
// combinationally while valid is high.
module frame_reader_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // A write into a full FIFO is accepted only when a read frees the slot in the same cycle.
  assign rd_ok   = rd_en && (count != '0);
  assign wr_ok   = wr_en && ((count != CW'(DEPTH)) || rd_ok);
  assign rd_data = mem[rd_ptr];
  assign valid   = (count != '0);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dram_frame_reader.sv
// Reads one frame back from DRAM in fixed-size bursts and streams it out as
// valid/ready beats, tagging the final beat of the frame.
module dram_frame_reader
  import image2dram_pkg::*;
#(
  parameter int                         DRAM_ADDR_WIDTH = 39,
  parameter int                         DRAM_DATA_WIDTH = 512,
  parameter logic [DRAM_ADDR_WIDTH-1:0] DRAM_ADDR_BASE  = 'h8000_0000,
  parameter int                         BURST_LEN       = 16,
  parameter int                         FIFO_DEPTH      = 64,
  parameter int                         BEAT_CNT_WIDTH  = 24
) (
  input  logic                       m_axi_aclk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [DRAM_ADDR_WIDTH-1:0] frame_offset,
  input  logic [BEAT_CNT_WIDTH-1:0]  frame_beats,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow_err,
  output logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  output logic [7:0]                 dram_read_len,
  output logic                       dram_read_en,
  input  logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  input  logic                       dram_read_data_valid,
  input  logic                       dram_read_busy,
  output logic [DRAM_DATA_WIDTH-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = BEAT_CNT_WIDTH;

  rd_state_t                  state;
  logic [DRAM_ADDR_WIDTH-1:0] addr;
  logic [BW-1:0]              remaining;
  logic [BW-1:0]              burst_cnt;
  logic [BW-1:0]              frame_len;
  logic [BW-1:0]              out_cnt;
  logic [BW-1:0]              burst_beats;
  logic [CW-1:0]              fifo_count;
  logic                       space_ok;
  logic                       issue;
  logic                       out_fire;
  logic                       fifo_room;
  logic                       beat_in;
  logic                       fifo_wr;
  logic                       burst_end;

  assign burst_beats = (remaining >= BW'(BURST_LEN)) ? BW'(BURST_LEN) : remaining;
  assign space_ok    = (32'(FIFO_DEPTH) - 32'(fifo_count)) >= 32'(burst_beats);

  // The burst request is combinational so it goes out in the very cycle the controller frees up.
  assign issue          = (state == ISSUE) && !dram_read_busy && space_ok;
  assign dram_read_en   = issue;
  assign dram_read_addr = issue ? addr : '0;
  assign dram_read_len  = issue ? 8'(burst_beats - BW'(1)) : '0;

  assign out_fire  = out_valid && out_ready;
  assign fifo_room = (fifo_count != CW'(FIFO_DEPTH)) || out_fire;
  assign beat_in   = dram_read_data_valid && (state == WAIT);
  assign fifo_wr   = beat_in && fifo_room;
  assign burst_end = beat_in && ((burst_cnt + BW'(1)) == burst_beats);
  assign out_last  = out_valid && busy && (out_cnt == frame_len - BW'(1));

  frame_reader_fifo #(
    .WIDTH (DRAM_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (m_axi_aclk),
    .rst     (reset),
    .wr_en   (fifo_wr),
    .wr_data (dram_read_data),
    .rd_en   (out_fire),
    .rd_data (out_data),
    .valid   (out_valid),
    .count   (fifo_count)
  );

  always_ff @(posedge m_axi_aclk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addr         <= '0;
      remaining    <= '0;
      burst_cnt    <= '0;
      frame_len    <= '0;
      out_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (dram_read_data_valid && !fifo_wr) overflow_err <= 1'b1;
      if (out_fire) out_cnt <= out_cnt + BW'(1);
      case (state)
        IDLE: begin
          if (start) begin
            if (frame_beats == '0) begin
              done <= 1'b1;
            end else begin
              addr      <= DRAM_ADDR_BASE + frame_offset;
              remaining <= frame_beats;
              frame_len <= frame_beats;
              out_cnt   <= '0;
              burst_cnt <= '0;
              busy      <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue) state <= WAIT;
        end
        WAIT: begin
          if (burst_end) begin
            burst_cnt <= '0;
            addr      <= addr + (DRAM_ADDR_WIDTH'(burst_beats) << BEAT_ADDR_SHIFT);
            remaining <= remaining - burst_beats;
            state     <= (remaining == burst_beats) ? DRAIN : ISSUE;
          end else if (beat_in) begin
            burst_cnt <= burst_cnt + BW'(1);
          end
        end
        DRAIN: begin
          if (out_fire && out_last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_frame_reader.sv
// Scoreboard bench: a DRAM controller model answers bursts, expected bursts and
// beats are queued at frame start and compared as the DUT produces them.
module tb_dram_frame_reader;

  localparam int AW = 39;
  localparam int DW = 512;
  localparam int BL = 16;
  localparam int FD = 32;
  localparam int BW = 24;
  localparam int ALIGN_BITS = $clog2(BL * 64);
  localparam logic [AW-1:0] BASE = 39'h80000000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] frame_offset = '0;
  logic [BW-1:0] frame_beats = '0;
  logic          busy, done, overflow_err;
  logic [AW-1:0] dram_read_addr;
  logic [7:0]    dram_read_len;
  logic          dram_read_en;
  logic [DW-1:0] dram_read_data = '0;
  logic          dram_read_data_valid = 1'b0;
  logic          dram_read_busy = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;

  typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } burst_t;
  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
  burst_t exp_bursts[$];
  beat_t  exp_beats[$];

  int total = 0, passed = 0;
  int en_cnt = 0, done_cnt = 0, beats_seen = 0;
  bit en_forbidden = 1'b0;
  bit spurious_req = 1'b0;

  always #5 clk = ~clk;

  dram_frame_reader #(
    .DRAM_ADDR_WIDTH (AW),
    .DRAM_DATA_WIDTH (DW),
    .DRAM_ADDR_BASE  (BASE),
    .BURST_LEN       (BL),
    .FIFO_DEPTH      (FD),
    .BEAT_CNT_WIDTH  (BW)
  ) dut (
    .m_axi_aclk           (clk),
    .reset                (reset),
    .start                (start),
    .frame_offset         (frame_offset),
    .frame_beats          (frame_beats),
    .busy                 (busy),
    .done                 (done),
    .overflow_err         (overflow_err),
    .dram_read_addr       (dram_read_addr),
    .dram_read_len        (dram_read_len),
    .dram_read_en         (dram_read_en),
    .dram_read_data       (dram_read_data),
    .dram_read_data_valid (dram_read_data_valid),
    .dram_read_busy       (dram_read_busy),
    .out_data             (out_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_last             (out_last)
  );

  // Controller model: beats start 3 cycles after the request, data encodes the beat byte address.
  initial begin : ctrl_model
    logic [63:0] m_addr;
    int m_left, m_delay;
    m_addr = '0; m_left = 0; m_delay = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_left = 0; m_delay = 0;
      end else if (dram_read_en) begin
        m_addr = 64'(dram_read_addr); m_left = int'(dram_read_len) + 1; m_delay = 3;
      end
      @(posedge clk); #1;
      dram_read_data_valid = 1'b0;
      if (m_delay > 0) m_delay--;
      if (spurious_req) begin
        dram_read_data_valid = 1'b1; dram_read_data = '1; spurious_req = 1'b0;
      end else if (m_delay == 0 && m_left > 0 && !reset) begin
        dram_read_data_valid = 1'b1; dram_read_data = {8{m_addr}};
        m_addr += 64; m_left--;
      end
    end
  end

  initial begin : monitor
    burst_t eb;
    beat_t  et;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (dram_read_en) begin
          en_cnt++; total++;
          if (en_forbidden) $display("FAIL burst_during_ctrl_busy: got en addr=%h, required none", dram_read_addr);
          else if (exp_bursts.size() == 0) $display("FAIL unexpected_burst: got addr=%h len=%0d, required none", dram_read_addr, dram_read_len);
          else begin
            eb = exp_bursts.pop_front();
            if ({dram_read_addr, dram_read_len} !== eb)
              $display("FAIL burst: got addr=%h len=%0d, required addr=%h len=%0d", dram_read_addr, dram_read_len, eb.addr, eb.len);
            else passed++;
          end
        end
        if (out_valid && out_ready) begin
          beats_seen++; total++;
          if (exp_beats.size() == 0) $display("FAIL unexpected_beat: got data=%h last=%b, required none", out_data[63:0], out_last);
          else begin
            et = exp_beats.pop_front();
            if ({out_data, out_last} !== et)
              $display("FAIL beat: got data=%h last=%b, required data=%h last=%b", out_data[63:0], out_last, et.data[63:0], et.last);
            else passed++;
          end
        end
        if (done) begin
          done_cnt++; total++;
          if (busy !== 1'b0) $display("FAIL done_busy: got busy=%b with done, required 0", busy);
          else passed++;
        end
      end
    end
  end

  task automatic start_frame(input logic [AW-1:0] off, input int n);
    logic [AW-1:0] a;
    int rem, b;
    a = BASE + off;
    assert (a[ALIGN_BITS-1:0] == '0) else $error("frame start %h not burst aligned", a);
    rem = n;
    while (rem > 0) begin
      b = (rem > BL) ? BL : rem;
      exp_bursts.push_back({a, 8'(b - 1)});
      a += AW'(b * 64);
      rem -= b;
    end
    a = BASE + off;
    for (int i = 0; i < n; i++) exp_beats.push_back({{8{64'(a + AW'(i * 64))}}, (i == n - 1)});
    @(posedge clk); #1;
    frame_offset = off; frame_beats = BW'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    int c;
    c = 0;
    while (done_cnt == d0 && c < budget) begin @(negedge clk); c++; end
    ok = (done_cnt != d0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, overflow_err, dram_read_en, out_valid, out_last, dram_read_addr, dram_read_len} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b en=%b ov=%b last=%b addr=%h len=%h, required all 0",
               busy, done, overflow_err, dram_read_en, out_valid, out_last, dram_read_addr, dram_read_len);
    else passed++;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || dut.fifo_count !== '0) $display("FAIL post_reset_idle: got busy=%b count=%0d, required 0/0", busy, dut.fifo_count);
    else passed++;
  endtask

  task automatic test_basic();
    int e0, d0; bit ok;
    e0 = en_cnt; d0 = done_cnt;
    out_ready = 1'b1;
    start_frame('0, 40);
    @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b, required 1", busy); else passed++;
    wait_done(d0, 2000, ok);
    total++; if (!ok) $display("FAIL basic_timeout: got no done, required done"); else passed++;
    total++; if (en_cnt - e0 != 3) $display("FAIL basic_bursts: got %0d, required 3", en_cnt - e0); else passed++;
    total++; if (done_cnt - d0 != 1) $display("FAIL basic_done_count: got %0d, required 1", done_cnt - d0); else passed++;
    total++;
    if (exp_beats.size() != 0 || exp_bursts.size() != 0)
      $display("FAIL basic_leftover: got beats=%0d bursts=%0d, required 0/0", exp_beats.size(), exp_bursts.size());
    else passed++;
    total++; if (overflow_err !== 1'b0) $display("FAIL basic_overflow: got %b, required 0", overflow_err); else passed++;
  endtask

  task automatic test_backpressure();
    int e0, d0, b0; bit ok;
    e0 = en_cnt; d0 = done_cnt; b0 = beats_seen;
    out_ready = 1'b0;
    start_frame(39'h10000, 64);
    repeat (200) @(negedge clk);
    total++; if (en_cnt - e0 != 2) $display("FAIL bp_stall_bursts: got %0d, required 2", en_cnt - e0); else passed++;
    total++; if (dut.fifo_count !== 6'd32) $display("FAIL bp_count: got %0d, required 32", dut.fifo_count); else passed++;
    total++; if (overflow_err !== 1'b0) $display("FAIL bp_overflow: got %b, required 0", overflow_err); else passed++;
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done(d0, 2000, ok);
    total++; if (!ok) $display("FAIL bp_timeout: got no done, required done"); else passed++;
    total++; if (en_cnt - e0 != 4) $display("FAIL bp_bursts: got %0d, required 4", en_cnt - e0); else passed++;
    total++; if (beats_seen - b0 != 64) $display("FAIL bp_beats: got %0d, required 64", beats_seen - b0); else passed++;
  endtask

  task automatic test_ctrl_busy();
    int e0, d0; bit ok;
    e0 = en_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    dram_read_busy = 1'b1; en_forbidden = 1'b1;
    start_frame(39'h400, 20);
    repeat (49) @(negedge clk);
    total++; if (en_cnt != e0) $display("FAIL cbusy_window: got %0d bursts, required 0", en_cnt - e0); else passed++;
    @(posedge clk); #1;
    dram_read_busy = 1'b0; en_forbidden = 1'b0;
    @(negedge clk);
    total++; if (dram_read_en !== 1'b1) $display("FAIL cbusy_first_issue: got en=%b, required 1", dram_read_en); else passed++;
    wait_done(d0, 2000, ok);
    total++;
    if (!ok || exp_beats.size() != 0) $display("FAIL cbusy_complete: got done=%b leftover=%0d, required 1/0", ok, exp_beats.size());
    else passed++;
  endtask

  task automatic test_edge_sizes();
    int e0, d0; bit ok;
    e0 = en_cnt; d0 = done_cnt;
    start_frame('0, 0);
    @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL zero_done: got %b, required 1", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b, required 0", busy); else passed++;
    repeat (5) @(negedge clk);
    total++; if (en_cnt != e0) $display("FAIL zero_no_access: got %0d bursts, required 0", en_cnt - e0); else passed++;
    total++; if (done_cnt - d0 != 1) $display("FAIL zero_done_count: got %0d, required 1", done_cnt - d0); else passed++;
    e0 = en_cnt; d0 = done_cnt;
    start_frame(39'h800, 1);
    wait_done(d0, 500, ok);
    total++; if (!ok) $display("FAIL one_timeout: got no done, required done"); else passed++;
    total++;
    if (en_cnt - e0 != 1 || exp_beats.size() != 0) $display("FAIL one_burst: got %0d bursts leftover=%0d, required 1/0", en_cnt - e0, exp_beats.size());
    else passed++;
  endtask

  task automatic test_start_while_busy();
    int e0, d0; bit ok;
    e0 = en_cnt; d0 = done_cnt;
    start_frame(39'h2000, 48);
    repeat (8) @(posedge clk);
    #1; start = 1'b1; frame_offset = 39'h5000; frame_beats = 24'd5;
    @(posedge clk); #1 start = 1'b0;
    wait_done(d0, 2000, ok);
    repeat (20) @(negedge clk);
    total++; if (!ok) $display("FAIL swb_timeout: got no done, required done"); else passed++;
    total++; if (en_cnt - e0 != 3) $display("FAIL swb_bursts: got %0d, required 3", en_cnt - e0); else passed++;
    total++; if (done_cnt - d0 != 1) $display("FAIL swb_done_count: got %0d, required 1", done_cnt - d0); else passed++;
  endtask

  task automatic test_reset_mid();
    int b0, d0, e1, c; bit ok;
    b0 = beats_seen;
    out_ready = 1'b1;
    start_frame(39'h3000, 64);
    c = 0;
    while (beats_seen - b0 < 20 && c < 1000) begin @(negedge clk); c++; end
    total++; if (beats_seen - b0 < 20) $display("FAIL rmid_progress: got %0d beats, required 20", beats_seen - b0); else passed++;
    reset = 1'b1;
    exp_bursts.delete(); exp_beats.delete();
    d0 = done_cnt;
    @(negedge clk);
    total++;
    if ({busy, done, overflow_err, dram_read_en, out_valid, out_last, dram_read_addr, dram_read_len} !== '0 || dut.fifo_count !== '0)
      $display("FAIL rmid_outputs: got busy=%b done=%b ovf=%b en=%b ov=%b last=%b count=%0d, required all 0",
               busy, done, overflow_err, dram_read_en, out_valid, out_last, dut.fifo_count);
    else passed++;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (done_cnt != d0) $display("FAIL rmid_no_done: got %0d done pulses, required 0", done_cnt - d0); else passed++;
    e1 = en_cnt; d0 = done_cnt;
    start_frame(39'h3000, 8);
    wait_done(d0, 500, ok);
    total++;
    if (!ok || en_cnt - e1 != 1 || exp_beats.size() != 0)
      $display("FAIL rmid_restart: got done=%b bursts=%0d leftover=%0d, required 1/1/0", ok, en_cnt - e1, exp_beats.size());
    else passed++;
  endtask

  task automatic test_spurious();
    total++; if (overflow_err !== 1'b0) $display("FAIL spur_pre: got %b, required 0", overflow_err); else passed++;
    @(posedge clk); #1 spurious_req = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (overflow_err !== 1'b1) $display("FAIL spur_flag: got %b, required 1", overflow_err); else passed++;
    total++;
    if (out_valid !== 1'b0 || dut.fifo_count !== '0) $display("FAIL spur_fifo: got valid=%b count=%0d, required 0/0", out_valid, dut.fifo_count);
    else passed++;
    repeat (10) @(negedge clk);
    total++; if (overflow_err !== 1'b1) $display("FAIL spur_sticky: got %b, required 1", overflow_err); else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++; if (overflow_err !== 1'b0) $display("FAIL spur_reset_clear: got %b, required 0", overflow_err); else passed++;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ctrl_busy();
    test_edge_sizes();
    test_start_while_busy();
    test_reset_mid();
    test_spurious();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
